priority_irq_ctrl: RTL and testbench
====================================

# priority_irq_ctrl

Parametrised, registered successor to the combinational 4-to-2 priority encoder. It captures N request lines into pending state and applies a per-line enable mask. It selects the highest-index enabled pending line and presents its index on a valid/ready handshake. It sits between peripheral request sources and a single consumer (CPU interrupt port or DMA sequencer) and removes a grant once the consumer accepts it.

## Interface
- N, 8, number of request lines; legal range 2..32.
- W, $clog2(N), index width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request lines, synchronous to clk; req[N-1] has highest priority.
- mask  in  N  per-line enable; 1 = line may be selected.
- out_idx  out  W  index of the offered line.
- out_valid  out  1  an index is being offered.
- out_ready  in  1  consumer accepts the offer.
- out_multi  out  1  more than one enabled pending line existed when the offer was latched.
- pending  out  N  current pending register, unmasked.

## Operation
- Reset values: pending=0, req_d=0, out_idx=0, out_valid=0, out_multi=0, state IDLE.
- req_d is req registered every cycle.
- Pending update: behaviour depends on IRQ_EDGE_EN; see Configuration.
- Candidate set: cand = pending & mask.
- FSM, two states:
  - IDLE: if cand != 0, latch out_idx = highest set index of cand, latch out_multi = (popcount(cand) > 1), set out_valid=1, go to OFFER. Otherwise remain in IDLE with out_valid=0.
  - OFFER: out_idx, out_multi and out_valid=1 hold stable while out_ready=0. Changes to mask, req or pending do not retract or alter an active offer. On out_valid & out_ready: out_valid=0, issue an ack-clear of pending[out_idx] (edge mode only), go to IDLE.
- Selection is strict fixed priority: highest index wins. Lower-priority lines can starve.
- If out_ready is high while out_valid=0, it is ignored.

## Timing
- Cycle numbering: req[i] goes high before edge t0.
  - Edge mode: pending[i]=1 after edge t0.
  - Level mode: req_d[i]=1 after edge t0.
  - out_valid=1 after edge t1.
  - Request-to-offer latency is 2 cycles.
- Accept at edge tA returns to IDLE. The next offer appears after edge tA+1 at the earliest. Maximum throughput is 1 grant per 2 cycles, and out_valid is low for at least 1 cycle between grants.
- Simultaneous set and ack-clear on the same bit in the same cycle: set wins, and the bit stays pending.
- A rise on any other bit during accept is captured normally.
- Asynchronous reset mid-offer: out_valid drops immediately and all pending requests are lost.
- req held high through reset release: req_d=0 after reset, so edge mode detects a rise on the first edge after release.

## Configuration
- IRQ_EDGE_EN defined (edge mode):
  - rise = req & ~req_d.
  - pending <= (pending & ~ackclr) | rise.
  - pending is sticky until the line is accepted. A pulse of one cycle is never lost.
  - A second rise while the line is still pending is merged into the existing pending bit.
- IRQ_EDGE_EN undefined (level mode):
  - pending = req_d, with no sticky state and no ack-clear.
  - The source must drop req after it is serviced. If req stays high, the same index is offered again 2 cycles after accept.

## Test plan
- Reset: hold rst_n=0, drive req=8'hFF and mask=8'hFF -> out_valid=0 and pending=0 throughout. After release, out_valid=1 with out_idx=7 on the second edge.
- Priority and mask (N=8): req=8'b0010_0110, mask=8'hDF -> out_idx=2, out_multi=1. Then drive mask=8'hFF during OFFER -> out_idx stays 2 until accept.
- Backpressure: out_ready=0 for 5 cycles with req[4] pending -> out_valid=1 and out_idx=4 stable for all 5 cycles. With out_ready=1 -> out_valid=0 on the next cycle.
- Edge mode: a 1-cycle pulse on req[3], then drive req[6] high during the accept cycle of idx 3 -> offer idx 3, then idx 6 with 1 idle cycle between. pending[3]=0 after the accept.
- Set and clear collision (edge mode): req[1] makes a new rise in the same cycle its idx-1 offer is accepted -> pending[1] remains 1 and idx 1 is offered again.
- Level mode: hold req[5] high for 10 cycles with out_ready=1 -> idx 5 is offered every 2 cycles. Drop req[5] -> out_valid stays low from 2 cycles later.

Source files
------------

// File: rtl/priority_irq_ctrl_if.sv
// Request/offer bundle between interrupt sources, the priority controller and its consumer.
// The controller side uses the master modport; the consumer/stimulus side uses slave.
interface priority_irq_ctrl_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic [N-1:0] pending;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
  logic         out_multi;

  modport master (
    input  req, mask, out_ready,
    output pending, out_idx, out_valid, out_multi
  );

  modport slave (
    output req, mask, out_ready,
    input  pending, out_idx, out_valid, out_multi
  );
endinterface

// File: rtl/priority_irq_ctrl.sv
// Registered fixed-priority interrupt controller: captures N requests, offers the highest enabled index.
// Define IRQ_EDGE_EN for sticky edge-captured pending bits; default is level mode (pending follows req_d).
module priority_irq_ctrl #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  priority_irq_ctrl_if.master  bus
);
  localparam int W = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] req_d;
  logic [N-1:0] pend;
  logic [N-1:0] cand;
  logic [W-1:0] idx;
  logic [W-1:0] idx_nxt;
  logic         valid;
  logic         valid_nxt;
  logic         multi;
  logic         multi_nxt;
  logic         accept;

  function automatic logic [W-1:0] top_index(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = W'(i);
      end
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic more_than_one(input logic [N-1:0] v);
    return (v & (v - ONE)) != {N{1'b0}};
  endfunction

  // Request delay register, used for rise detection and as the level-mode pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d <= {N{1'b0}};
    end else begin
      req_d <= bus.req;
    end
  end

`ifdef IRQ_EDGE_EN
  logic [N-1:0] ackclr;
  assign ackclr = accept ? (ONE << idx) : {N{1'b0}};

  // Sticky pending bits; a rise in the accept cycle outranks the ack-clear of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= {N{1'b0}};
    end else begin
      pend <= (pend & ~ackclr) | (bus.req & ~req_d);
    end
  end
`else
  assign pend = req_d;
`endif

  assign cand   = pend & bus.mask;
  assign accept = (state == OFFER) & bus.out_ready;

  // State and offer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= {W{1'b0}};
      multi <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      multi <= multi_nxt;
      valid <= valid_nxt;
    end
  end

  // Next-state and offer latching; an active offer is frozen until accepted.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    multi_nxt = multi;
    valid_nxt = valid;
    case (state)
      IDLE: begin
        if (cand != {N{1'b0}}) begin
          state_nxt = OFFER;
          idx_nxt   = top_index(cand);
          multi_nxt = more_than_one(cand);
          valid_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b0;
        end
      end
      OFFER: begin
        if (accept) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.pending   = pend;
  assign bus.out_idx   = idx;
  assign bus.out_valid = valid;
  assign bus.out_multi = multi;
endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Scoreboard bench for priority_irq_ctrl (N=8); expectations follow IRQ_EDGE_EN when it is defined.
module tb_priority_irq_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  typedef struct packed {
    logic [2:0] idx;
    logic       multi;
  } exp_t;

  exp_t q[$];

  priority_irq_ctrl_if #(.N(8)) bus ();

  priority_irq_ctrl #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] i, input logic m);
    exp_t e;
    e.idx   = i;
    e.multi = m;
    q.push_back(e);
  endtask

  task automatic queue_empty(input string name);
    chk(name, q.size(), 32'd0);
  endtask

  // Monitor: every accepted offer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got idx %0d expected no grant", bus.out_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("grant_idx", {29'd0, bus.out_idx}, {29'd0, e.idx});
        chk("grant_multi", {31'd0, bus.out_multi}, {31'd0, e.multi});
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req = 8'hFF;
    bus.mask = 8'hFF;
    bus.out_ready = 1'b0;

    // Reset held with all requests active
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_pending", {24'd0, bus.pending}, 32'd0);
    end
    rst_n = 1'b1;
    tick(1);
    chk("rel_e1_valid", {31'd0, bus.out_valid}, 32'd0);
    tick(1);
    chk("rel_e2_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rel_e2_idx", {29'd0, bus.out_idx}, 32'd7);
    chk("rel_e2_multi", {31'd0, bus.out_multi}, 32'd1);
    push(3'd7, 1'b1);
`ifdef IRQ_EDGE_EN
    for (int i = 6; i >= 0; i--) begin
      push(3'(i), (i != 0) ? 1'b1 : 1'b0);
    end
`endif
    bus.req = 8'h00;
    bus.out_ready = 1'b1;
    tick(18);
    bus.out_ready = 1'b0;
    queue_empty("rst_drain");
    chk("rst_drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Priority with mask; widening the mask mid-offer must not alter the offer
    bus.req = 8'b0010_0110;
    bus.mask = 8'hDF;
    push(3'd2, 1'b1);
`ifdef IRQ_EDGE_EN
    push(3'd5, 1'b1);
    push(3'd1, 1'b0);
`endif
    tick(2);
    chk("prio_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("prio_idx", {29'd0, bus.out_idx}, 32'd2);
    chk("prio_multi", {31'd0, bus.out_multi}, 32'd1);
    bus.mask = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      chk("mask_hold_idx", {29'd0, bus.out_idx}, 32'd2);
      chk("mask_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.req = 8'h00;
    bus.out_ready = 1'b1;
    tick(8);
    bus.out_ready = 1'b0;
    queue_empty("prio_drain");

    // Backpressure: offer of idx 4 held for 5 cycles
    bus.req = 8'h10;
    push(3'd4, 1'b0);
    tick(2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_idx", {29'd0, bus.out_idx}, 32'd4);
      tick(1);
    end
    bus.req = 8'h00;
    bus.out_ready = 1'b1;
    tick(1);
    chk("bp_accept_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_accept_pending", {24'd0, bus.pending}, 32'd0);
    bus.out_ready = 1'b0;
    tick(2);
    queue_empty("bp_drain");

`ifdef IRQ_EDGE_EN
    // Single-cycle pulse on req[3], then req[6] rises during its accept
    bus.req = 8'h08;
    push(3'd3, 1'b0);
    push(3'd6, 1'b0);
    tick(1);
    bus.req = 8'h00;
    tick(1);
    chk("pulse_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pulse_idx", {29'd0, bus.out_idx}, 32'd3);
    bus.out_ready = 1'b1;
    bus.req = 8'h40;
    tick(1);
    chk("pulse_gap_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("pulse_pending", {24'd0, bus.pending}, 32'h40);
    bus.req = 8'h00;
    tick(1);
    chk("pulse_next_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pulse_next_idx", {29'd0, bus.out_idx}, 32'd6);
    tick(1);
    chk("pulse_end_pending", {24'd0, bus.pending}, 32'd0);
    bus.out_ready = 1'b0;
    tick(2);
    queue_empty("pulse_drain");

    // New rise on req[1] in the same cycle its offer is accepted
    bus.req = 8'h02;
    push(3'd1, 1'b0);
    push(3'd1, 1'b0);
    tick(1);
    bus.req = 8'h00;
    tick(1);
    chk("coll_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("coll_idx", {29'd0, bus.out_idx}, 32'd1);
    bus.out_ready = 1'b1;
    bus.req = 8'h02;
    tick(1);
    chk("coll_gap_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("coll_pending", {24'd0, bus.pending}, 32'h02);
    bus.req = 8'h00;
    tick(1);
    chk("coll_again_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("coll_again_idx", {29'd0, bus.out_idx}, 32'd1);
    tick(1);
    chk("coll_end_pending", {24'd0, bus.pending}, 32'd0);
    bus.out_ready = 1'b0;
    tick(2);
    queue_empty("coll_drain");
`else
    // Level mode: req[5] held 10 cycles with a ready consumer
    bus.out_ready = 1'b1;
    bus.req = 8'h20;
    for (int k = 0; k < 5; k++) begin
      push(3'd5, 1'b0);
    end
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("lvl_valid", {31'd0, bus.out_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.req = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("lvl_drop_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    bus.out_ready = 1'b0;
    queue_empty("lvl_drain");
`endif

    // Asynchronous reset during an active offer
    bus.req = 8'h01;
    tick(2);
    chk("arst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("arst_pre_idx", {29'd0, bus.out_idx}, 32'd0);
    bus.req = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_pending", {24'd0, bus.pending}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("arst_after_valid", {31'd0, bus.out_valid}, 32'd0);
    queue_empty("final_queue");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
